wb_stage: RTL and testbench

- Registered MEM/WB boundary and writeback stage of the RV32IC pipeline.
- Captures the memory-stage result, sign/zero-extends and aligns load data, and selects the writeback source: ALU result, load data or link address.
- Drives the register file write port: write register, write data, write enable.
- Also provides a forwarding copy of the WB value, a misaligned-load exception flag and a 64-bit retired-instruction counter.

---
 rtl/wb_stage.sv | 122 ++++++++++++
 tb/tb_wb_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage: load extraction, writeback source
// select, forwarding copy, misaligned-load flag and retired-instruction counter.
module wb_stage #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         flush,
   input  logic         mem_valid,
   input  logic [4:0]   mem_rd,
   input  logic         mem_reg_write,
   input  logic [1:0]   mem_to_reg,
   input  logic [N-1:0] mem_alu_result,
   input  logic [N-1:0] mem_pc,
   input  logic         mem_is_compressed,
   input  logic [2:0]   mem_funct3,
   input  logic [N-1:0] mem_rdata,
   output logic [4:0]   wb_write_reg,
   output logic [N-1:0] wb_wr_data,
   output logic         wb_reg_write,
   output logic         fwd_valid,
   output logic [4:0]   fwd_rd,
   output logic [N-1:0] fwd_data,
   output logic         load_misaligned,
   output logic [N-1:0] misaligned_addr,
   output logic [63:0]  instret
);

   // Little-endian lane extraction with sign/zero extension; illegal funct3 yields 0.
   function automatic logic [N-1:0] load_extract(input logic [2:0]   f3,
                                                  input logic [1:0]   off,
                                                  input logic [N-1:0] word);
      logic [7:0]   b;
      logic [15:0]  h;
      logic [N-1:0] res;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  res = {{(N-8){b[7]}}, b};
         3'b001:  res = {{(N-16){h[15]}}, h};
         3'b010:  res = word;
         3'b100:  res = {{(N-8){1'b0}}, b};
         3'b101:  res = {{(N-16){1'b0}}, h};
         default: res = '0;
      endcase
      return res;
   endfunction

   logic [1:0]   off;
   logic         is_load;
   logic         misaligned;
   logic         illegal_load;
   logic         do_write;
   logic         retire;
   logic [N-1:0] link_addr;
   logic [N-1:0] sel_data;

   logic [4:0]   write_reg_p0;
   logic [N-1:0] wr_data_p0;
   logic         reg_write_p0;
   logic         mis_p0;
   logic [N-1:0] mis_addr_p0;
   logic [63:0]  instret_p0;

   always_comb begin
      off          = mem_alu_result[1:0];
      is_load      = (mem_to_reg == 2'b01);
      misaligned   = 1'b0;
      illegal_load = 1'b0;
      if (is_load) begin
         case (mem_funct3)
            3'b001, 3'b101:         misaligned   = off[0];
            3'b010:                 misaligned   = (off != 2'b00);
            3'b011, 3'b110, 3'b111: illegal_load = 1'b1;
            default:                misaligned   = 1'b0;
         endcase
      end
      misaligned = misaligned & mem_valid;
      do_write   = mem_valid & mem_reg_write & (mem_rd != 5'd0) & ~misaligned & ~illegal_load;
      retire     = mem_valid & ~misaligned;
      link_addr  = mem_pc + (mem_is_compressed ? N'(2) : N'(4));
      case (mem_to_reg)
         2'b01:   sel_data = load_extract(mem_funct3, off, mem_rdata);
         2'b10:   sel_data = link_addr;
         default: sel_data = mem_alu_result;
      endcase
   end

   // MEM -> WB boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         write_reg_p0 <= '0;
         wr_data_p0   <= '0;
         reg_write_p0 <= 1'b0;
         mis_p0       <= 1'b0;
         mis_addr_p0  <= '0;
         instret_p0   <= '0;
      end else if (flush) begin
         reg_write_p0 <= 1'b0;
         mis_p0       <= 1'b0;
      end else if (!stall) begin
         write_reg_p0 <= mem_rd;
         wr_data_p0   <= sel_data;
         reg_write_p0 <= do_write;
         mis_p0       <= misaligned;
         if (misaligned) mis_addr_p0 <= mem_alu_result;
         if (retire)     instret_p0  <= instret_p0 + 64'd1;
      end
   end

   assign wb_write_reg    = write_reg_p0;
   assign wb_wr_data      = wr_data_p0;
   assign wb_reg_write    = reg_write_p0;
   assign fwd_valid       = reg_write_p0;
   assign fwd_rd          = write_reg_p0;
   assign fwd_data        = wr_data_p0;
   assign load_misaligned = mis_p0;
   assign misaligned_addr = mis_addr_p0;
   assign instret         = instret_p0;

endmodule

// File: tb/tb_wb_stage.sv
// Directed table-driven bench for wb_stage plus hand-written stall/flush/wrap/reset sequences.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, mem_valid, mem_reg_write, mem_is_compressed;
   logic [4:0]  mem_rd;
   logic [1:0]  mem_to_reg;
   logic [31:0] mem_alu_result, mem_pc, mem_rdata;
   logic [2:0]  mem_funct3;
   logic [4:0]  wb_write_reg, fwd_rd;
   logic [31:0] wb_wr_data, fwd_data, misaligned_addr;
   logic        wb_reg_write, fwd_valid, load_misaligned;
   logic [63:0] instret;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_stage #(.N(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .mem_to_reg(mem_to_reg), .mem_alu_result(mem_alu_result), .mem_pc(mem_pc),
      .mem_is_compressed(mem_is_compressed), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
      .wb_write_reg(wb_write_reg), .wb_wr_data(wb_wr_data), .wb_reg_write(wb_reg_write),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .load_misaligned(load_misaligned), .misaligned_addr(misaligned_addr), .instret(instret)
   );

   typedef struct {
      logic        valid;
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  to_reg;
      logic [31:0] alu;
      logic [31:0] pc;
      logic        comp;
      logic [2:0]  f3;
      logic        exp_we;
      logic [31:0] exp_data;
      logic        chk_data;
      logic        exp_mis;
      logic [31:0] exp_addr;
      logic [63:0] exp_instret;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] tr,
                        input logic [31:0] alu, input logic [31:0] pc, input logic comp,
                        input logic [2:0] f3);
      mem_valid = v; mem_rd = rd; mem_reg_write = rw; mem_to_reg = tr;
      mem_alu_result = alu; mem_pc = pc; mem_is_compressed = comp; mem_funct3 = f3;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " wb_reg_write"}, 64'(wb_reg_write), 64'd0);
      chk({tag, " wb_write_reg"}, 64'(wb_write_reg), 64'd0);
      chk({tag, " wb_wr_data"}, 64'(wb_wr_data), 64'd0);
      chk({tag, " load_misaligned"}, 64'(load_misaligned), 64'd0);
      chk({tag, " misaligned_addr"}, 64'(misaligned_addr), 64'd0);
      chk({tag, " fwd_valid"}, 64'(fwd_valid), 64'd0);
      chk({tag, " instret"}, instret, 64'd0);
   endtask

   initial begin
      //          v  rd  rw to     alu            pc          c  f3      we data          cd mis addr          instret
      vecs[0]  = '{1, 5, 1, 2'b01, 32'h2001,     32'h0,      0, 3'b000, 1, 32'hFFFF_FFF2, 1, 0, 32'h0,     64'd1};
      vecs[1]  = '{1, 5, 1, 2'b01, 32'h2003,     32'h0,      0, 3'b100, 1, 32'h0000_0080, 1, 0, 32'h0,     64'd2};
      vecs[2]  = '{1, 5, 1, 2'b01, 32'h2002,     32'h0,      0, 3'b001, 1, 32'hFFFF_8081, 1, 0, 32'h0,     64'd3};
      vecs[3]  = '{1, 5, 1, 2'b01, 32'h2000,     32'h0,      0, 3'b101, 1, 32'h0000_F2A3, 1, 0, 32'h0,     64'd4};
      vecs[4]  = '{1, 5, 1, 2'b01, 32'h2000,     32'h0,      0, 3'b010, 1, 32'h8081_F2A3, 1, 0, 32'h0,     64'd5};
      vecs[5]  = '{1, 1, 1, 2'b10, 32'h0,        32'h100,    1, 3'b000, 1, 32'h0000_0102, 1, 0, 32'h0,     64'd6};
      vecs[6]  = '{1, 1, 1, 2'b10, 32'h0,        32'h100,    0, 3'b000, 1, 32'h0000_0104, 1, 0, 32'h0,     64'd7};
      vecs[7]  = '{1, 0, 1, 2'b00, 32'h55,       32'h0,      0, 3'b000, 0, 32'h0000_0055, 1, 0, 32'h0,     64'd8};
      vecs[8]  = '{1, 5, 1, 2'b01, 32'h1002,     32'h0,      0, 3'b010, 0, 32'h0,         0, 1, 32'h1002,  64'd8};
      vecs[9]  = '{1, 5, 1, 2'b01, 32'h1003,     32'h0,      0, 3'b001, 0, 32'h0,         0, 1, 32'h1003,  64'd8};
      vecs[10] = '{1, 5, 1, 2'b01, 32'h2000,     32'h0,      0, 3'b011, 0, 32'h0,         0, 0, 32'h1003,  64'd9};
      vecs[11] = '{0, 5, 1, 2'b00, 32'h77,       32'h0,      0, 3'b000, 0, 32'h0000_0077, 1, 0, 32'h1003,  64'd9};
      vecs[12] = '{1, 31, 1, 2'b11, 32'hDEADBEEF, 32'hFFFF_FFFC, 0, 3'b000, 1, 32'hDEAD_BEEF, 1, 0, 32'h1003, 64'd10};
      vecs[13] = '{1, 5, 1, 2'b01, 32'h2000,     32'h0,      0, 3'b100, 1, 32'h0000_00A3, 1, 0, 32'h1003,  64'd11};

      mem_rdata = 32'h8081_F2A3;
      stall = 0; flush = 0;

      // Reset with a live instruction presented: nothing may leak through.
      rst = 1;
      drive(1, 5'd7, 1, 2'b00, 32'h1234, 32'h40, 0, 3'b000);
      repeat (2) @(posedge clk);
      #1 chk_zero("reset");

      @(negedge clk);
      rst = 0;
      drive(0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 0, 3'b000);
      @(posedge clk); #1 chk_zero("bubble");

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(vecs[i].valid, vecs[i].rd, vecs[i].rw, vecs[i].to_reg, vecs[i].alu,
               vecs[i].pc, vecs[i].comp, vecs[i].f3);
         @(posedge clk); #1;
         chk($sformatf("v%0d wb_reg_write", i), 64'(wb_reg_write), 64'(vecs[i].exp_we));
         chk($sformatf("v%0d fwd_valid", i), 64'(fwd_valid), 64'(vecs[i].exp_we));
         chk($sformatf("v%0d wb_write_reg", i), 64'(wb_write_reg), 64'(vecs[i].rd));
         chk($sformatf("v%0d fwd_rd", i), 64'(fwd_rd), 64'(vecs[i].rd));
         if (vecs[i].chk_data) begin
            chk($sformatf("v%0d wb_wr_data", i), 64'(wb_wr_data), 64'(vecs[i].exp_data));
            chk($sformatf("v%0d fwd_data", i), 64'(fwd_data), 64'(vecs[i].exp_data));
         end
         chk($sformatf("v%0d load_misaligned", i), 64'(load_misaligned), 64'(vecs[i].exp_mis));
         chk($sformatf("v%0d misaligned_addr", i), 64'(misaligned_addr), 64'(vecs[i].exp_addr));
         chk($sformatf("v%0d instret", i), instret, vecs[i].exp_instret);
      end

      // Capture ALU 0xAA to rd=3, then stall with different inputs for 3 cycles.
      @(negedge clk);
      drive(1, 5'd3, 1, 2'b00, 32'hAA, 32'h0, 0, 3'b000);
      @(posedge clk); #1;
      chk("stall_pre data", 64'(wb_wr_data), 64'hAA);
      chk("stall_pre instret", instret, 64'd12);
      @(negedge clk);
      stall = 1;
      drive(1, 5'd9, 1, 2'b00, 32'h77, 32'h0, 0, 3'b000);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("stall%0d data", c), 64'(wb_wr_data), 64'hAA);
         chk($sformatf("stall%0d rd", c), 64'(wb_write_reg), 64'd3);
         chk($sformatf("stall%0d we", c), 64'(wb_reg_write), 64'd1);
         chk($sformatf("stall%0d instret", c), instret, 64'd12);
      end
      @(negedge clk);
      flush = 1;
      @(posedge clk); #1;
      chk("flush+stall we", 64'(wb_reg_write), 64'd0);
      chk("flush+stall fwd_valid", 64'(fwd_valid), 64'd0);
      chk("flush+stall instret", instret, 64'd12);

      // Flush must also drop a pending misaligned flag but keep its address.
      @(negedge clk);
      flush = 0; stall = 0;
      drive(1, 5'd5, 1, 2'b01, 32'h1002, 32'h0, 0, 3'b010);
      @(posedge clk); #1;
      chk("mis2 flag", 64'(load_misaligned), 64'd1);
      @(negedge clk);
      flush = 1;
      drive(1, 5'd6, 1, 2'b00, 32'h99, 32'h0, 0, 3'b000);
      @(posedge clk); #1;
      chk("flush mis flag", 64'(load_misaligned), 64'd0);
      chk("flush we", 64'(wb_reg_write), 64'd0);
      chk("flush mis addr", 64'(misaligned_addr), 64'h1002);
      chk("flush instret", instret, 64'd12);

      // Counter wrap via deposit away from the clock edge.
      @(negedge clk);
      flush = 0;
      dut.instret_p0 <= 64'hFFFF_FFFF_FFFF_FFFF;
      drive(1, 5'd4, 0, 2'b00, 32'h1, 32'h0, 0, 3'b000);
      @(posedge clk); #1;
      chk("wrap instret", instret, 64'd0);
      chk("wrap we (rw=0)", 64'(wb_reg_write), 64'd0);

      // Reset mid-stream discards the pending entry.
      @(negedge clk);
      rst = 1;
      drive(1, 5'd8, 1, 2'b01, 32'h1001, 32'h0, 0, 3'b001);
      @(posedge clk); #1 chk_zero("midrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
